// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the alignment rule.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      WR,
      RESP
   } state_t;

   // Size 3 is never legal; halves need an even address, words a 4-byte boundary.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = offset[0];
         SZ_WORD: misaligned = (offset != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Big-endian lane steering: sub-word store merge and load extraction with
// optional sign extension. Purely combinational.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] merged,
   output logic [31:0] extended
);

   function automatic logic [31:0] merge(input logic [31:0] rw, input logic [31:0] wd,
                                         input logic [1:0] off, input logic [1:0] sz);
      logic [31:0] word;
      word = rw;
      case (sz)
         SZ_BYTE: begin
            case (off)
               2'd0:    word[31:24] = wd[7:0];
               2'd1:    word[23:16] = wd[7:0];
               2'd2:    word[15:8]  = wd[7:0];
               default: word[7:0]   = wd[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off[1]) word[15:0]  = wd[15:0];
            else        word[31:16] = wd[15:0];
         end
         SZ_WORD: word = wd;
         default: word = rw;
      endcase
      return word;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] rw, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] ext;
      case (off)
         2'd0:    b = rw[31:24];
         2'd1:    b = rw[23:16];
         2'd2:    b = rw[15:8];
         default: b = rw[7:0];
      endcase
      h = off[1] ? rw[15:0] : rw[31:16];
      case (sz)
         SZ_BYTE: ext = sg ? 32'(b) : {24'd0, b};
         SZ_HALF: ext = sg ? 32'(h) : {16'd0, h};
         SZ_WORD: ext = rw;
         default: ext = '0;
      endcase
      return ext;
   endfunction

   assign merged   = merge(rword, wdata, offset, size);
   assign extended = extract(rword, offset, size, sign);

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage controller for a word-wide syncram: one request at a time,
// read-modify-write for sub-word stores, extended load data, alignment errors.
module dmem_ctrl
   import dmem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        ram_cs,
   output logic        ram_oe,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout
);

   state_t      state, next;
   logic        we_r, sign_r, err_r;
   logic [1:0]  size_r;
   logic [31:0] addr_r, wdata_r, rbuf, rbuf_next, merge_r, rdata_r;
   logic [31:0] merged, extended;
   logic        accept, bad;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign bad       = misaligned(req_size, req_addr[1:0]);

   // The RAM word is only valid during CAP; the lane sees it there directly.
   assign rbuf_next = (state == CAP) ? ram_dout : rbuf;

   dmem_lane u_lane (
      .rword    (rbuf_next),
      .wdata    (wdata_r),
      .offset   (addr_r[1:0]),
      .size     (size_r),
      .sign     (sign_r),
      .merged   (merged),
      .extended (extended)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         we_r    <= 1'b0;
         sign_r  <= 1'b0;
         size_r  <= 2'd0;
         addr_r  <= '0;
         wdata_r <= '0;
         rbuf    <= '0;
         merge_r <= '0;
         rdata_r <= '0;
         err_r   <= 1'b0;
      end else begin
         state <= next;
         rbuf  <= rbuf_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  we_r    <= req_we;
                  sign_r  <= req_signed;
                  size_r  <= req_size;
                  addr_r  <= req_addr;
                  wdata_r <= req_wdata;
                  merge_r <= req_wdata;
                  rdata_r <= '0;
                  err_r   <= bad;
               end
            end
            CAP: begin
               if (we_r) merge_r <= merged;
               else      rdata_r <= extended;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next       = state;
      ram_cs     = 1'b0;
      ram_oe     = 1'b0;
      ram_we     = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bad)                              next = RESP;
               else if (req_we && req_size == SZ_WORD) next = WR;
               else                                  next = RD;
            end
         end
         RD: begin
            ram_cs = 1'b1;
            ram_oe = 1'b1;
            next   = CAP;
         end
         CAP:  next = we_r ? WR : RESP;
         WR: begin
            ram_cs = 1'b1;
            ram_we = 1'b1;
            next   = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            next       = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   assign resp_rdata = resp_valid ? rdata_r : 32'd0;
   assign resp_err   = resp_valid & err_r;
   assign ram_addr   = {addr_r[31:2], 2'b00};
   assign ram_din    = merge_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: syncram model, byte-addressed reference memory,
// directed cases followed by randomized requests.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        ram_cs, ram_oe, ram_we;
   logic [31:0] ram_addr, ram_din, ram_dout;

   logic [31:0] ram  [0:255];
   logic [7:0]  refb [0:1023];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .ram_cs     (ram_cs),
      .ram_oe     (ram_oe),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout)
   );

   // syncram: registered read, synchronous write
   always @(posedge clk) begin
      if (ram_cs && ram_we) ram[ram_addr[9:2]] <= ram_din;
      if (ram_cs && ram_oe) ram_dout <= ram[ram_addr[9:2]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int a);
      return {refb[a], refb[a+1], refb[a+2], refb[a+3]};
   endfunction

   // Byte-level reference: big-endian, size-scaled latency and RAM cycle counts.
   task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] e_rd, output logic e_err,
                        output int e_lat, output int e_nrd, output int e_nwr);
      int n, base;
      longint v;
      n     = (sz == 2'd3) ? 0 : (1 << sz);
      base  = int'(a[9:0]);
      e_rd  = 32'd0;
      e_err = 1'b0;
      e_nrd = 0;
      e_nwr = 0;
      if (n == 0 || (base % n) != 0) begin
         e_err = 1'b1;
         e_lat = 1;
      end else if (we) begin
         for (int i = 0; i < n; i++)
            refb[base+i] = 8'((wd >> (8*(n-1-i))) & 32'hFF);
         e_nwr = 1;
         e_nrd = (n == 4) ? 0 : 1;
         e_lat = (n == 4) ? 2 : 4;
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v = v * 256 + longint'(refb[base+i]);
         if (sg && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
         e_rd  = v[31:0];
         e_nrd = 1;
         e_lat = 3;
      end
   endtask

   task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
      logic [31:0] e_rd;
      logic        e_err, er;
      int          e_lat, e_nrd, e_nwr, lat, nrd, nwr, ncs;
      model(we, sz, sg, a, wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 99; nrd = 0; nwr = 0; ncs = 0; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 8; k++) begin
         if (ram_cs) ncs++;
         if (ram_cs && ram_oe) nrd++;
         if (ram_cs && ram_we) nwr++;
         if (resp_valid) begin
            lat = k; rd = resp_rdata; er = resp_err;
            break;
         end
         @(posedge clk); #1;
      end
      check($sformatf("%s.lat", tag), lat, e_lat);
      check($sformatf("%s.rdata", tag), rd, e_rd);
      check($sformatf("%s.err", tag), {31'd0, er}, {31'd0, e_err});
      check($sformatf("%s.reads", tag), nrd, e_nrd);
      check($sformatf("%s.writes", tag), nwr, e_nwr);
      check($sformatf("%s.cs", tag), ncs, e_nrd + e_nwr);
   endtask

   initial begin
      logic [31:0] rd, e_rd, a, wd;
      logic        e_err;
      logic [5:0]  rdy_pat, rv_pat;
      logic [31:0] rd6;
      int          e_lat, e_nrd, e_nwr;
      logic [1:0]  sz;

      for (int i = 0; i < 256; i++) ram[i] = 32'd0;
      for (int i = 0; i < 1024; i++) refb[i] = 8'd0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

      #2;
      check("rst.ready", {31'd0, req_ready}, 32'd0);
      check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst.strobes", {29'd0, ram_cs, ram_oe, ram_we}, 32'd0);
      check("rst.rdata", resp_rdata, 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      check("rst.ready_after", {31'd0, req_ready}, 32'd1);

      run_req("sw", 1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, rd);
      run_req("lw", 1'b0, 2'd2, 1'b1, 32'h100, 32'h0, rd);
      check("lw.const", rd, 32'h11223344);
      run_req("sb", 1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AA, rd);
      @(posedge clk); #1;
      check("sb.ram", ram[64], 32'h11AA3344);
      run_req("lbs", 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, rd);
      check("lbs.const", rd, 32'hFFFFFFAA);
      run_req("lbu", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, rd);
      check("lbu.const", rd, 32'h000000AA);
      run_req("sh", 1'b1, 2'd1, 1'b0, 32'h102, 32'h00008001, rd);
      @(posedge clk); #1;
      check("sh.ram", ram[64], 32'h11AA8001);
      run_req("lhs", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, rd);
      check("lhs.const", rd, 32'hFFFF8001);
      run_req("lhu", 1'b0, 2'd1, 1'b0, 32'h100, 32'h0, rd);
      check("lhu.const", rd, 32'h000011AA);

      run_req("err_lw", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rd);
      run_req("err_sh", 1'b1, 2'd1, 1'b0, 32'h103, 32'h5555, rd);
      run_req("err_sz3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, rd);
      check("err_sh.ram", ram[64], 32'h11AA8001);

      // valid held across a word store and a following word load
      model(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, e_rd, e_err, e_lat, e_nrd, e_nwr);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h104; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_we = 1'b0;
      rdy_pat = '0; rv_pat = '0; rd6 = '0;
      for (int k = 1; k <= 6; k++) begin
         rdy_pat[k-1] = req_ready;
         rv_pat[k-1]  = resp_valid;
         if (k == 6) rd6 = resp_rdata;
         if (k == 4) req_valid = 1'b0;
         @(posedge clk); #1;
      end
      check("hold.ready", {26'd0, rdy_pat}, 32'b000100);
      check("hold.resp", {26'd0, rv_pat}, 32'b100010);
      check("hold.rdata", rd6, 32'hCAFEF00D);

      // reset during RD must drop the strobes at once
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_addr = 32'h100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rd.cs_before", {31'd0, ram_cs}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rd.async_cs", {31'd0, ram_cs}, 32'd0);
      check("rd.async_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // reset during CAP of a byte store
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h101; req_wdata = 32'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      rdy_pat = '0; rv_pat = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         rdy_pat[k] = ram_we | ram_cs;
         rv_pat[k]  = resp_valid;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      check("caprst.strobes", {26'd0, rdy_pat}, 32'd0);
      check("caprst.resp", {26'd0, rv_pat}, 32'd0);
      @(posedge clk); #1;
      check("caprst.ready", {31'd0, req_ready}, 32'd1);
      check("caprst.ram", ram[64], ref_word(32'h100));

      for (int n = 0; n < 60; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         wd = $urandom;
         run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz,
                 1'($urandom_range(0, 1)), a, wd, rd);
      end

      @(posedge clk); #1;
      for (int w = 0; w < 256; w++) begin
         if (ram[w] !== ref_word(w*4)) check($sformatf("final.ram%0d", w), ram[w], ref_word(w*4));
      end
      check("final.ram_sample", ram[64], ref_word(32'h100));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
